seg_display_arbiter: RTL and testbench
======================================

Name: seg_display_arbiter

Overview:
Shares the board's two 7-segment digits and four LEDs between two requesters: port A (core debug/output) and port B (switch-driven test pattern). Each requester offers an 8-bit value over a valid/ready handshake. Arbitration is round-robin. An accepted value is shown as two hex digits and held for a minimum dwell time before another value can be accepted. The block sits between the core/test logic and the board display pins.

Parameters:
DWELL_CYCLES, 4194304, number of clock cycles an accepted value is held before the next accept (must be >= 1)
DWELL_W, 22, width of the dwell timer (must hold DWELL_CYCLES-1)

Ports:
i_Clk  input  1  system clock, all state on rising edge
i_Rst_L  input  1  asynchronous active-low reset
i_A_Valid  input  1  requester A has a value
i_A_Data  input  8  requester A value
o_A_Ready  output  1  A transfer occurs on an edge where i_A_Valid & o_A_Ready
i_B_Valid  input  1  requester B has a value
i_B_Data  input  8  requester B value
o_B_Ready  output  1  B transfer occurs on an edge where i_B_Valid & o_B_Ready
o_Segment1  output  7  high-nibble digit, bits [6:0] = G,F,E,D,C,B,A, active-low
o_Segment2  output  7  low-nibble digit, same encoding
o_LED  output  4  status, see below
o_Busy  output  1  high while in DWELL

Behaviour:
- Reset (i_Rst_L low, asynchronous):
  - state IDLE; shown_valid=0; shown data=0x00; owner=none; last_grant=B; timer=0.
  - o_A_Ready and o_B_Ready are forced 0 for the whole time reset is asserted.
  - Both segment buses = 7'b1111111 (blank); o_LED=0; o_Busy=0.
- FSM has two states:
  - IDLE: ready is combinational. grant = A if only A is valid; B if only B is valid; if both are valid, grant the requester that is not last_grant; no grant if neither is valid. Only the granted port's ready is high. Ready may therefore depend on valid.
  - IDLE -> DWELL on a transfer edge: latch data; owner=grant; last_grant=grant; shown_valid=1; timer=DWELL_CYCLES-1.
  - DWELL: both readys are 0. Timer decrements each cycle. On the edge where timer==0, go to IDLE.
- Timing:
  - The accept at edge k puts the block in DWELL for exactly DWELL_CYCLES cycles.
  - Earliest next accept is edge k+DWELL_CYCLES+1.
  - With DWELL_CYCLES=1, accepts are spaced 2 edges apart.
- Display:
  - Segment outputs are decoded combinationally from registered state and change right after the transfer edge (zero added latency).
  - Standard hex font, lowercase b and d. Examples: 0 = 1000000, 5 = 0010010, A = 0001000, F = 0001110.
  - Shown value persists after DWELL until the next accept.
- o_LED:
  - [0] = owner is A; [1] = owner is B.
  - [2] = o_Busy.
  - [3] = (i_A_Valid | i_B_Valid) & (state==DWELL), i.e. a request is waiting.
- Requesters must hold valid and data stable until accepted. If valid drops early, the block takes no transfer and recomputes the grant on the next cycle; no state changes.
- Reset asserted mid-DWELL: display blanks immediately; the pending dwell is discarded. After release, the block is in IDLE with last_grant=B.
- Timer arithmetic is unsigned DWELL_W bits, with no wrap: decrement only while nonzero in DWELL.

Test Plan:
- Use DWELL_CYCLES=4. Reset, then release. Required: segments both 1111111, LEDs 0000, no ready while reset is low.
- A valid with 0x5A alone. Required: o_A_Ready=1 in the same cycle; after the edge, o_Segment1=0010010, o_Segment2=0001000, o_LED=0101, o_Busy high for exactly 4 cycles.
- A (0x11) and B (0x22) valid together from reset. Required: A accepted first (last_grant=B); B accepted 5 edges later; display shows 22 with o_LED[1]=1.
- Both requesters held valid continuously. Required: grants alternate A,B,A,B with accepts exactly 5 edges apart; o_LED[3]=1 during every DWELL.
- B sends 0xF0, then reset is pulsed low for 1 cycle at the 2nd DWELL cycle. Required: immediate blank, IDLE after release; a held B request is re-accepted on the next edge after release.
- Sweep A through 0x00–0xFF with no B traffic. Required: each nibble's segment pattern matches the hex font table; no value is skipped or accepted twice.

Source files
------------

// File: rtl/seg_display_arbiter.sv
// Round-robin arbiter sharing two hex 7-segment digits and status LEDs
// between two valid/ready requesters, with a minimum dwell per value.
module seg_display_arbiter #(
    parameter int DWELL_CYCLES = 4194304,
    parameter int DWELL_W      = 22
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_A_Valid,
    input  logic [7:0] i_A_Data,
    output logic       o_A_Ready,
    input  logic       i_B_Valid,
    input  logic [7:0] i_B_Data,
    output logic       o_B_Ready,
    output logic [6:0] o_Segment1,
    output logic [6:0] o_Segment2,
    output logic [3:0] o_LED,
    output logic       o_Busy
);

    typedef enum logic {
        IDLE,
        DWELL
    } state_t;

    localparam logic [DWELL_W-1:0] DWELL_LOAD = DWELL_W'(DWELL_CYCLES - 1);
    localparam logic [DWELL_W-1:0] DWELL_ONE  = DWELL_W'(1);

    state_t               state, state_nxt;
    logic [DWELL_W-1:0]   timer, timer_nxt;
    logic [7:0]           data_q, data_nxt;
    logic                 shown_valid, shown_nxt;
    logic [1:0]           owner, owner_nxt;
    logic                 last_b, last_b_nxt;
    logic                 grant_a, grant_b;

    // Ties go to whoever did not win last; ready is never raised in reset
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (i_Rst_L && state == IDLE) begin
            grant_a = i_A_Valid & (~i_B_Valid | last_b);
            grant_b = i_B_Valid & (~i_A_Valid | ~last_b);
        end
    end

    assign o_A_Ready = grant_a;
    assign o_B_Ready = grant_b;

    always_comb begin
        state_nxt  = state;
        timer_nxt  = timer;
        data_nxt   = data_q;
        shown_nxt  = shown_valid;
        owner_nxt  = owner;
        last_b_nxt = last_b;
        unique case (state)
            IDLE: begin
                if (grant_a || grant_b) begin
                    state_nxt  = DWELL;
                    timer_nxt  = DWELL_LOAD;
                    data_nxt   = grant_b ? i_B_Data : i_A_Data;
                    shown_nxt  = 1'b1;
                    owner_nxt  = grant_b ? 2'b10 : 2'b01;
                    last_b_nxt = grant_b;
                end
            end
            DWELL: begin
                if (timer == '0) begin
                    state_nxt = IDLE;
                end else begin
                    timer_nxt = timer - DWELL_ONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state       <= IDLE;
            timer       <= '0;
            data_q      <= 8'h00;
            shown_valid <= 1'b0;
            owner       <= 2'b00;
            last_b      <= 1'b1;
        end else begin
            state       <= state_nxt;
            timer       <= timer_nxt;
            data_q      <= data_nxt;
            shown_valid <= shown_nxt;
            owner       <= owner_nxt;
            last_b      <= last_b_nxt;
        end
    end

    // Active-low GFEDCBA, lowercase b and d
    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        s = 7'b1111111;
        unique case (n)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            4'hF: s = 7'b0001110;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    assign o_Segment1 = shown_valid ? hex7(data_q[7:4]) : 7'b1111111;
    assign o_Segment2 = shown_valid ? hex7(data_q[3:0]) : 7'b1111111;
    assign o_Busy     = (state == DWELL);
    assign o_LED      = {(i_A_Valid | i_B_Valid) & o_Busy, o_Busy, owner[1], owner[0]};

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Scoreboard bench for seg_display_arbiter: cycle-count reference model,
// queue-fed requesters and a decoupled monitor.
module tb_seg_display_arbiter;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       A_valid = 1'b0;
    logic [7:0] A_Data = 8'h00;
    logic       B_valid = 1'b0;
    logic [7:0] B_Data = 8'h00;
    logic       A_ready, B_ready, busy;
    logic [6:0] seg1, seg2;
    logic [3:0] led;

    seg_display_arbiter #(.DWELL_CYCLES(N), .DWELL_W(3)) dut (
        .i_Clk(clk), .i_Rst_L(rst_n),
        .i_A_Valid(A_valid), .i_A_Data(A_Data), .o_A_Ready(A_ready),
        .i_B_Valid(B_valid), .i_B_Data(B_Data), .o_B_Ready(B_ready),
        .o_Segment1(seg1), .o_Segment2(seg2), .o_LED(led), .o_Busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [6:0] font [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    logic [8:0] sb_q[$];
    logic [7:0] a_q[$];
    logic [7:0] b_q[$];
    logic       log_port[$];
    logic [7:0] log_data[$];
    int         log_cyc[$];
    bit         drop_mode = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: time-based dwell window, round-robin tie-break
    logic       m_last_b = 1'b1;
    int         m_next_ok = 0;
    logic       m_shown_v = 1'b0;
    logic [7:0] m_shown = 8'h00;
    int         m_own = 0;
    logic       e_ra, e_rb, e_busy;
    logic [6:0] e_seg1, e_seg2;
    logic [3:0] e_led;

    initial begin
        logic mbusy, ga, gb;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_last_b = 1'b1; m_next_ok = 0;
                m_shown_v = 1'b0; m_shown = 8'h00; m_own = 0;
                e_ra = 0; e_rb = 0; e_busy = 0; e_led = 4'h0;
                e_seg1 = 7'h7F; e_seg2 = 7'h7F;
            end else begin
                mbusy = (cyc + 1 < m_next_ok);
                e_seg1 = m_shown_v ? font[m_shown[7:4]] : 7'h7F;
                e_seg2 = m_shown_v ? font[m_shown[3:0]] : 7'h7F;
                e_busy = mbusy;
                e_led = {(A_valid | B_valid) & mbusy, mbusy,
                         m_own == 2, m_own == 1};
                ga = !mbusy && A_valid && (!B_valid || m_last_b);
                gb = !mbusy && B_valid && (!A_valid || !m_last_b);
                e_ra = ga; e_rb = gb;
                if (ga || gb) begin
                    sb_q.push_back({gb, gb ? B_Data : A_Data});
                    m_last_b = gb;
                    m_own = gb ? 2 : 1;
                    m_shown = gb ? B_Data : A_Data;
                    m_shown_v = 1'b1;
                    m_next_ok = cyc + 1 + N + 1;
                end
            end
        end
    end

    // Monitor
    initial begin
        logic [8:0] e;
        forever begin
            @(negedge clk);
            #1;
            chk("a_ready", A_ready, e_ra);
            chk("b_ready", B_ready, e_rb);
            chk("seg1", seg1, e_seg1);
            chk("seg2", seg2, e_seg2);
            chk("led", led, e_led);
            chk("busy", busy, e_busy);
            if ((A_valid && A_ready) || (B_valid && B_ready)) begin
                log_port.push_back(B_valid && B_ready);
                log_data.push_back((B_valid && B_ready) ? B_Data : A_Data);
                log_cyc.push_back(cyc + 1);
                if (sb_q.size() == 0) begin
                    chk("spurious_xfer", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    chk("xfer_port", B_valid && B_ready, e[8]);
                    chk("xfer_data", (B_valid && B_ready) ? B_Data : A_Data, e[7:0]);
                end
            end
            if (sb_q.size() != 0) begin
                chk("missed_xfer", 0, sb_q.size());
                sb_q.delete();
            end
        end
    end

    // Requesters: hold each queued value until accepted
    initial begin
        logic ta, tb;
        forever begin
            @(negedge clk);
            #2;
            ta = A_valid & A_ready;
            tb = B_valid & B_ready;
            @(posedge clk);
            #2;
            if (ta) A_valid = 0;
            if (tb) B_valid = 0;
            if (drop_mode && A_valid && $urandom_range(7) == 0) A_valid = 0;
            if (drop_mode && B_valid && $urandom_range(7) == 0) B_valid = 0;
            if (!A_valid && a_q.size() > 0) begin
                A_Data = a_q.pop_front(); A_valid = 1;
            end
            if (!B_valid && b_q.size() > 0) begin
                B_Data = b_q.pop_front(); B_valid = 1;
            end
        end
    end

    task automatic drain(int budget);
        int n;
        n = 0;
        while ((a_q.size() != 0 || b_q.size() != 0 || A_valid || B_valid)
               && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk("drain_in_time", n < budget, 1);
        repeat (N + 2) @(posedge clk);
        #2;
    endtask

    initial begin
        int s, k;
        // reset with A already requesting: no ready until release
        a_q.push_back(8'h5A);
        repeat (4) @(posedge clk);
        #2 rst_n = 1;
        drain(50);
        chk("first_data", log_data[0], 8'h5A);

        // simultaneous A/B right out of reset
        rst_n = 0;
        a_q.push_back(8'h11);
        b_q.push_back(8'h22);
        repeat (2) @(posedge clk);
        #2 rst_n = 1;
        s = log_data.size();
        drain(50);
        chk("tie_count", log_data.size() - s, 2);
        chk("tie_first_a", log_port[s], 0);
        chk("tie_second_b", log_port[s+1], 1);
        chk("tie_gap", log_cyc[s+1] - log_cyc[s], N + 1);
        chk("tie_seg1", seg1, font[2]);
        chk("tie_led1", led[1], 1);

        // continuous contention alternates A,B with fixed spacing
        s = log_data.size();
        for (int i = 0; i < 4; i++) begin
            a_q.push_back(8'($urandom));
            b_q.push_back(8'($urandom));
        end
        drain(100);
        chk("alt_count", log_data.size() - s, 8);
        for (int i = 0; i < 8; i++) begin
            chk("alt_port", log_port[s+i], i % 2);
            if (i > 0) chk("alt_gap", log_cyc[s+i] - log_cyc[s+i-1], N + 1);
        end

        // reset pulse in the 2nd dwell cycle with B still requesting
        s = log_data.size();
        b_q.push_back(8'hF0);
        b_q.push_back(8'hF0);
        k = 0;
        while (log_data.size() == s && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("f0_accept_in_time", k < 20, 1);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 0;
        #1;
        chk("rst_seg1_blank", seg1, 7'h7F);
        chk("rst_seg2_blank", seg2, 7'h7F);
        chk("rst_led", led, 4'h0);
        @(posedge clk);
        #2 rst_n = 1;
        k = cyc;
        drain(50);
        chk("rerun_count", log_data.size() - s, 2);
        chk("rerun_port", log_port[s+1], 1);
        chk("rerun_data", log_data[s+1], 8'hF0);
        chk("rerun_edge", log_cyc[s+1], k + 1);

        // full A sweep, no B traffic
        s = log_data.size();
        for (int i = 0; i < 256; i++) a_q.push_back(8'(i));
        drain(256 * (N + 2) + 50);
        chk("sweep_count", log_data.size() - s, 256);
        for (int i = 0; i < 256 && s + i < log_data.size(); i++) begin
            chk("sweep_data", log_data[s+i], i);
            chk("sweep_port", log_port[s+i], 0);
        end

        // random traffic with early valid drops
        drop_mode = 1;
        for (int r = 0; r < 40; r++) begin
            if ($urandom_range(1)) a_q.push_back(8'($urandom));
            if ($urandom_range(1)) b_q.push_back(8'($urandom));
            repeat ($urandom_range(6)) @(posedge clk);
        end
        drain(2000);
        drop_mode = 0;

        chk("sb_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
